// File: rtl/dct_pkg.sv
// Shared definitions for the DCT accumulation datapath: controller states,
// default geometry and a generic sign-extension helper.
package dct_pkg;

    localparam int DEFAULT_SIZE    = 16;
    localparam int DEFAULT_N_TERMS = 8;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_HOLD    = 2'd2
    } acc_state_e;

    // Replicates bit (from_w-1) of val into every bit above it.
    function automatic logic [63:0] sign_extend(input logic [63:0] val, input int unsigned from_w);
        logic [63:0] res;
        logic [5:0]  msb;
        msb = 6'(from_w - 32'd1);
        res = val;
        for (int i = 0; i < 64; i++) begin
            if (i >= int'(from_w)) begin
                res[i] = val[msb];
            end else begin
                res[i] = val[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/comp_three_two.sv
// Bitwise 3:2 compressor; when approximation is enabled the lowest APPROX_BITS
// columns use an OR in place of the full adder and generate no carry.
module comp_three_two #(
    parameter int W           = 16,
    parameter int APPROX_BITS = 0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic         approx_en,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    localparam logic [W-1:0] LOW_MASK = {W{1'b1}} >> (W - APPROX_BITS);

    logic [W-1:0] exact_sum_s;
    logic [W-1:0] exact_carry_s;

    // Full-adder columns with optional low-order approximation overlay.
    always_comb begin
        exact_sum_s   = a ^ b ^ c;
        exact_carry_s = (a & b) | (a & c) | (b & c);
        if (approx_en) begin
            sum   = (exact_sum_s & ~LOW_MASK) | ((a | b | c) & LOW_MASK);
            carry = exact_carry_s & ~LOW_MASK;
        end else begin
            sum   = exact_sum_s;
            carry = exact_carry_s;
        end
    end

endmodule

// File: rtl/csa_dot_accum.sv
// Carry-save dot-product accumulator: folds signed terms into a sum/carry pair,
// resolves them with one registered add and holds the result on valid/ready.
module csa_dot_accum
    import dct_pkg::*;
#(
    parameter  int SIZE        = DEFAULT_SIZE,
    parameter  int N_TERMS     = DEFAULT_N_TERMS,
    parameter  int APPROX_BITS = 0,
    localparam int ACC_SIZE    = SIZE + $clog2(N_TERMS),
    localparam int CNT_W       = $clog2(N_TERMS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                approx_en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE-1:0]     in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_SIZE-1:0] out_data,
    output logic [CNT_W-1:0]    out_count,
    output logic                out_trunc
);

    acc_state_e          state_q, state_d;
    logic [ACC_SIZE-1:0] sum_q, sum_d;
    logic [ACC_SIZE-1:0] carry_q, carry_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                approx_q, approx_d;
    logic                trunc_pend_q, trunc_pend_d;
    logic [ACC_SIZE-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]    out_count_q, out_count_d;
    logic                out_trunc_q, out_trunc_d;

    logic [ACC_SIZE-1:0] term_ext_s;
    logic [ACC_SIZE-1:0] carry_shl_s;
    logic [ACC_SIZE-1:0] comp_sum_s;
    logic [ACC_SIZE-1:0] comp_carry_s;
    logic [CNT_W-1:0]    count_inc_s;

    assign term_ext_s  = ACC_SIZE'(sign_extend(64'(in_data), SIZE));
    assign carry_shl_s = {carry_q[ACC_SIZE-2:0], 1'b0};
    assign count_inc_s = count_q + CNT_W'(1);

    comp_three_two #(
        .W           (ACC_SIZE),
        .APPROX_BITS (APPROX_BITS)
    ) u_comp (
        .a         (term_ext_s),
        .b         (sum_q),
        .c         (carry_shl_s),
        .approx_en (approx_q),
        .sum       (comp_sum_s),
        .carry     (comp_carry_s)
    );

    // Next-state and datapath updates for the accumulate/resolve/hold sequence.
    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        count_d      = count_q;
        approx_d     = approx_q;
        trunc_pend_d = trunc_pend_q;
        out_data_d   = out_data_q;
        out_count_d  = out_count_q;
        out_trunc_d  = out_trunc_q;
        case (state_q)
            ST_ACCUM: begin
                if (in_valid) begin
                    sum_d   = comp_sum_s;
                    carry_d = comp_carry_s;
                    count_d = count_inc_s;
                    if (count_q == CNT_W'(0)) begin
                        approx_d = approx_en;
                    end else begin
                        approx_d = approx_q;
                    end
                    // A full vector without in_last is force-terminated.
                    if (in_last || (count_inc_s == CNT_W'(N_TERMS))) begin
                        state_d      = ST_RESOLVE;
                        trunc_pend_d = ~in_last;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_RESOLVE: begin
                out_data_d   = sum_q + carry_shl_s;
                out_count_d  = count_q;
                out_trunc_d  = trunc_pend_q;
                sum_d        = '0;
                carry_d      = '0;
                count_d      = '0;
                trunc_pend_d = 1'b0;
                state_d      = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ACCUM;
            sum_q        <= '0;
            carry_q      <= '0;
            count_q      <= '0;
            approx_q     <= 1'b0;
            trunc_pend_q <= 1'b0;
            out_data_q   <= '0;
            out_count_q  <= '0;
            out_trunc_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            carry_q      <= carry_d;
            count_q      <= count_d;
            approx_q     <= approx_d;
            trunc_pend_q <= trunc_pend_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
            out_trunc_q  <= out_trunc_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_csa_dot_accum.sv
// Self-checking bench for csa_dot_accum: directed and random term streams
// compared against an integer-sum reference model.
module tb_csa_dot_accum;

    localparam int SIZE        = 16;
    localparam int N_TERMS     = 8;
    localparam int APPROX_BITS = 0;
    localparam int ACC_SIZE    = 19;
    localparam int CNT_W       = 4;
    localparam longint MASK    = longint'((64'd1 << ACC_SIZE) - 64'd1);

    logic                clk = 1'b0;
    logic                rst;
    logic                approx_en;
    logic                in_valid;
    logic                in_ready;
    logic [SIZE-1:0]     in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [ACC_SIZE-1:0] out_data;
    logic [CNT_W-1:0]    out_count;
    logic                out_trunc;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic signed [SIZE-1:0] s_data[$];
    bit                     s_last[$];

    csa_dot_accum #(
        .SIZE        (SIZE),
        .N_TERMS     (N_TERMS),
        .APPROX_BITS (APPROX_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .approx_en (approx_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_trunc (out_trunc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic push(input int v, input bit last);
        s_data.push_back(SIZE'(v));
        s_last.push_back(last);
    endtask

    task automatic check_idle_reset();
        check("rst_in_ready",  longint'(in_ready),  1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data",  longint'(out_data),  0);
        check("rst_out_count", longint'(out_count), 0);
        check("rst_out_trunc", longint'(out_trunc), 0);
    endtask

    // Plays the queued stream with in_valid held high; results are checked
    // against plain integer sums, each held for hold_min..hold_max cycles.
    task automatic run_stream(input int hold_min, input int hold_max);
        longint e_data[$];
        int     e_cnt[$];
        bit     e_tr[$];
        int     term_edge[$];
        longint acc;
        int     n, idx, n_run, hold_ctr, hold_tgt, cycles;
        bit     seen, prev_hs, acc_now, hs_now;
        acc = 0;
        n = 0;
        foreach (s_data[i]) begin
            acc += longint'(s_data[i]);
            n++;
            if (s_last[i] || n == N_TERMS) begin
                e_data.push_back(acc & MASK);
                e_cnt.push_back(n);
                e_tr.push_back(!s_last[i]);
                acc = 0;
                n = 0;
            end
        end
        idx = 0; n_run = 0; hold_ctr = 0; hold_tgt = 0; cycles = 0;
        seen = 0; prev_hs = 0;
        while ((idx < s_data.size() || e_data.size() > 0) && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            if (prev_hs) begin
                check("ready_after_hs", longint'(in_ready), 1);
                check("valid_after_hs", longint'(out_valid), 0);
            end
            if (out_valid) begin
                if (e_data.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    if (!seen) begin
                        seen = 1;
                        hold_ctr = 0;
                        hold_tgt = $urandom_range(hold_max, hold_min);
                        check("latency", longint'(cyc), longint'(term_edge[0] + 1));
                    end
                    check("out_data",  longint'(out_data),  e_data[0]);
                    check("out_count", longint'(out_count), longint'(e_cnt[0]));
                    check("out_trunc", longint'(out_trunc), longint'(e_tr[0]));
                    check("hold_in_ready", longint'(in_ready), 0);
                end
            end
            in_valid  = (idx < s_data.size());
            in_data   = in_valid ? s_data[idx] : '0;
            in_last   = in_valid ? s_last[idx] : 1'b0;
            approx_en = 1'($urandom_range(1, 0));
            out_ready = out_valid && seen && (hold_ctr >= hold_tgt);
            if (out_valid) hold_ctr++;
            acc_now = in_valid && in_ready;
            hs_now  = out_valid && out_ready;
            if (acc_now) begin
                n_run++;
                if (s_last[idx] || n_run == N_TERMS) begin
                    term_edge.push_back(cyc + 1);
                    n_run = 0;
                end
                idx++;
            end
            if (hs_now) begin
                void'(e_data.pop_front());
                void'(e_cnt.pop_front());
                void'(e_tr.pop_front());
                void'(term_edge.pop_front());
                seen = 0;
            end
            prev_hs = hs_now;
        end
        if (cycles >= 3000) check("stream_timeout", 0, 1);
        @(negedge clk);
        if (prev_hs) begin
            check("ready_after_hs", longint'(in_ready), 1);
            check("valid_after_hs", longint'(out_valid), 0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        s_data.delete();
        s_last.delete();
    endtask

    initial begin
        rst = 1'b1; approx_en = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_reset();
        rst = 1'b0;

        // Exact sum, full 8-term vector terminated by in_last.
        push(5, 0); push(9, 0); push(-23, 0); push(44, 0);
        push(100, 0); push(-1, 0); push(0, 0); push(7, 1);
        run_stream(0, 0);

        // Reset mid-vector discards the partial accumulation.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = SIZE'(1000 + i); in_last = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_reset();
        push(11, 0); push(-4, 1);
        run_stream(0, 0);

        // Single most-negative term held under backpressure.
        push(-32768, 1);
        run_stream(5, 5);

        // Nine max-positive terms: forced termination, ninth starts a new vector.
        for (int i = 0; i < 9; i++) push(32767, 0);
        push(1, 1);
        run_stream(0, 1);

        // Approximation request has no effect with APPROX_BITS=0.
        push(1, 0); push(2, 0); push(3, 1);
        run_stream(0, 2);

        // Two back-to-back random 8-term vectors.
        for (int v = 0; v < 2; v++)
            for (int i = 0; i < 8; i++) push(int'($urandom_range(65535, 0)) - 32768, i == 7);
        run_stream(0, 0);

        // Random vectors, some longer than N_TERMS.
        for (int v = 0; v < 6; v++) begin
            int len;
            len = $urandom_range(10, 1);
            for (int i = 0; i < len; i++) push(int'($urandom_range(65535, 0)) - 32768, i == len - 1);
        end
        run_stream(0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
